// File: rtl/raster_timing_ctrl.sv
// Raster timing generator: chained horizontal/vertical counters with phase
// decode, gated by a run/busy frame handshake so only whole frames are emitted.
module raster_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_en,
  input  logic                        run,
  output logic                        busy,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output logic                        line_start,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          running;
  logic          frame_end;

  // Handshake: run is a level request sampled only in IDLE and at the last
  // tick of a frame; busy stays high from the first RUN cycle until the frame
  // in flight has consumed its final tick, so a dropped run never truncates.
  assign running   = (state_q == ST_RUN);
  assign frame_end = running && pix_en && (h_q == H_LAST) && (v_q == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        // A pix_en coinciding with the start request is not counted.
        h_d = '0;
        v_d = '0;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pix_en) begin
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              v_d = '0;
              if (!run) state_d = ST_IDLE;
            end else begin
              v_d = v_q + 1'b1;
            end
          end else begin
            h_d = h_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  assign busy        = running;
  assign dbg_state   = state_q;
  assign hsync       = (running && (h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (running && (v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
  assign de          = running && (h_q < H_ACT_END) && (v_q < V_ACT_END);
  assign x           = de ? h_q[XW-1:0] : '0;
  assign y           = de ? v_q[YW-1:0] : '0;
  assign line_start  = running && pix_en && (h_q == '0);
  assign frame_start = running && pix_en && (h_q == '0) && (v_q == '0);
  assign frame_done  = frame_end;

endmodule
